// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - sequences the CMP comparator for conditional jumps and owns the PC.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [15:0]     instr_word,
  input  logic [15:0]     n_imm,
  input  logic [PC_W-1:0] target_addr,
  output logic [3:0]      rd_addr,
  output logic [3:0]      rs_addr,
  input  logic            reg_valid,
  output logic [3:0]      cmp_cond,
  output logic [15:0]     cmp_n,
  input  logic            cmp_jump,
  output logic [PC_W-1:0] pc,
`ifdef BRANCH_STATS_EN
  output logic [15:0]     taken_count,
  output logic [15:0]     not_taken_count,
`endif
  output logic            branch_taken,
  output logic            illegal_cond
);

  typedef enum logic [1:0] {IDLE, READ, EVAL, UPDATE} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [15:0]     n_q, n_d;
  logic [3:0]      cond_q, cond_d;
  logic [3:0]      rd_q, rd_d;
  logic [3:0]      rs_q, rs_d;
  logic [3:0]      cmp_cond_q, cmp_cond_d;
  logic [15:0]     cmp_n_q, cmp_n_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;
  logic            cond_legal;

  // Legal codes are 0000-0110 and 1000-1011.
  assign cond_legal = cond_q[3] ? ~cond_q[2] : (cond_q != 4'b0111);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    n_d        = n_q;
    cond_d     = cond_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    cmp_cond_d = cmp_cond_q;
    cmp_n_d    = cmp_n_q;
    taken_d    = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (instr_word[15:12] == 4'hF) begin
            cond_d  = instr_word[11:8];
            rd_d    = instr_word[7:4];
            rs_d    = instr_word[3:0];
            n_d     = n_imm;
            tgt_d   = target_addr;
            state_d = READ;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      READ: begin
        if (reg_valid) begin
          cmp_cond_d = cond_q;
          cmp_n_d    = n_q;
          state_d    = EVAL;
        end
      end
      EVAL: begin
        // The comparator has had the whole EVAL cycle to settle.
        taken_d   = cmp_jump & cond_legal;
        illegal_d = ~cond_legal;
        state_d   = UPDATE;
      end
      UPDATE: begin
        pc_d    = taken_q ? tgt_q : pc_q + PC_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      n_q        <= '0;
      cond_q     <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      cmp_cond_q <= '0;
      cmp_n_q    <= '0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      n_q        <= n_d;
      cond_q     <= cond_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      cmp_cond_q <= cmp_cond_d;
      cmp_n_q    <= cmp_n_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] ntaken_cnt_q, ntaken_cnt_d;

  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (state_q == UPDATE) begin
      if (taken_q) begin
        if (taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
      end else begin
        if (ntaken_cnt_q != 16'hFFFF) ntaken_cnt_d = ntaken_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign taken_count     = taken_cnt_q;
  assign not_taken_count = ntaken_cnt_q;
`endif

  assign instr_ready  = (state_q == IDLE);
  assign pc           = pc_q;
  assign rd_addr      = rd_q;
  assign rs_addr      = rs_q;
  assign cmp_cond     = cmp_cond_q;
  assign cmp_n        = cmp_n_q;
  assign branch_taken = taken_q;
  assign illegal_cond = illegal_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - directed self-checking bench for branch_sequencer.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [15:0] n_imm;
  logic [15:0] target_addr;
  logic [3:0]  rd_addr;
  logic [3:0]  rs_addr;
  logic        reg_valid;
  logic [3:0]  cmp_cond;
  logic [15:0] cmp_n;
  logic        cmp_jump;
  logic [15:0] pc;
  logic        branch_taken;
  logic        illegal_cond;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count;
  logic [15:0] not_taken_count;
`endif

  int checks = 0;
  int errors = 0;

  branch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_word(instr_word), .n_imm(n_imm), .target_addr(target_addr),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .reg_valid(reg_valid),
    .cmp_cond(cmp_cond), .cmp_n(cmp_n), .cmp_jump(cmp_jump),
    .pc(pc),
`ifdef BRANCH_STATS_EN
    .taken_count(taken_count), .not_taken_count(not_taken_count),
`endif
    .branch_taken(branch_taken), .illegal_cond(illegal_cond)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a branch with reg_valid already high, run it to completion and check the final PC.
  task automatic run_branch(input logic [15:0] word, input logic [15:0] tgt,
                            input logic jump, input logic [15:0] exp_pc);
    instr_valid = 1'b1; instr_word = word; target_addr = tgt;
    reg_valid = 1'b1; cmp_jump = jump;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("rb_taken", {31'd0, branch_taken}, {31'd0, jump});
    tick();
    check("rb_pc", {16'd0, pc}, {16'd0, exp_pc});
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_word = '0; n_imm = '0;
    target_addr = '0; reg_valid = 1'b0; cmp_jump = 1'b0;
    tick(); tick();
    check("rst_pc", {16'd0, pc}, 32'h0);
    check("rst_ready", {31'd0, instr_ready}, 32'h1);
    check("rst_rd_rs", {24'd0, rd_addr, rs_addr}, 32'h0);
    check("rst_cmp", {12'd0, cmp_cond, cmp_n}, 32'h0);
    check("rst_pulses", {30'd0, branch_taken, illegal_cond}, 32'h0);
    reset = 1'b0;

    // Non-branch stream: one instruction per cycle.
    instr_valid = 1'b1; instr_word = 16'h1000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("nb_pc", {16'd0, pc}, i);
      check("nb_ready", {31'd0, instr_ready}, 32'h1);
    end
    instr_valid = 1'b0;

    // Taken branch, cond 0, rd=1 rs=2.
    instr_valid = 1'b1; instr_word = 16'hF012; target_addr = 16'h0040;
    n_imm = 16'h0003; reg_valid = 1'b1; cmp_jump = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("tk_ready_read", {31'd0, instr_ready}, 32'h0);
    check("tk_rd", {28'd0, rd_addr}, 32'h1);
    check("tk_rs", {28'd0, rs_addr}, 32'h2);
    tick();
    check("tk_cmp_n", {16'd0, cmp_n}, 32'h3);
    check("tk_cmp_cond", {28'd0, cmp_cond}, 32'h0);
    check("tk_pc_eval", {16'd0, pc}, 32'h3);
    tick();
    check("tk_taken_upd", {31'd0, branch_taken}, 32'h1);
    check("tk_pc_upd", {16'd0, pc}, 32'h3);
    tick();
    check("tk_pc_new", {16'd0, pc}, 32'h40);
    check("tk_taken_off", {31'd0, branch_taken}, 32'h0);
    check("tk_ready_back", {31'd0, instr_ready}, 32'h1);

    // Not-taken with four stall cycles; a held instr_valid must not be re-captured.
    instr_valid = 1'b1; instr_word = 16'hF834; n_imm = 16'h0005;
    reg_valid = 1'b0; cmp_jump = 1'b0;
    tick();
    instr_word = 16'h1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_ready", {31'd0, instr_ready}, 32'h0);
      check("st_pc", {16'd0, pc}, 32'h40);
    end
    instr_valid = 1'b0; reg_valid = 1'b1;
    tick();
    check("st_cmp_n", {16'd0, cmp_n}, 32'h5);
    check("st_cmp_cond", {28'd0, cmp_cond}, 32'h8);
    check("st_rd_rs", {24'd0, rd_addr, rs_addr}, 32'h34);
    tick();
    check("st_taken", {31'd0, branch_taken}, 32'h0);
    tick();
    check("st_pc_new", {16'd0, pc}, 32'h41);

    // Illegal cond 0111 with cmp_jump high is forced not-taken.
    instr_valid = 1'b1; instr_word = 16'hF700; target_addr = 16'h1234; cmp_jump = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    check("il_pulse", {31'd0, illegal_cond}, 32'h1);
    check("il_taken", {31'd0, branch_taken}, 32'h0);
    tick();
    check("il_pulse_off", {31'd0, illegal_cond}, 32'h0);
    check("il_pc", {16'd0, pc}, 32'h42);

    // Self-loop target, then jump to all-ones and wrap on a non-branch.
    run_branch(16'hF0AB, 16'h0042, 1'b1, 16'h0042);
    run_branch(16'hFB00, 16'hFFFF, 1'b1, 16'hFFFF);
    instr_valid = 1'b1; instr_word = 16'h2000;
    tick();
    instr_valid = 1'b0;
    check("wrap_pc", {16'd0, pc}, 32'h0);

    // Asynchronous reset during READ.
    instr_valid = 1'b1; instr_word = 16'hF056; target_addr = 16'h0100; reg_valid = 1'b0;
    tick();
    instr_valid = 1'b0;
    check("ar_in_read", {31'd0, instr_ready}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("ar_ready", {31'd0, instr_ready}, 32'h1);
    check("ar_rd_rs", {24'd0, rd_addr, rs_addr}, 32'h0);
    check("ar_pc", {16'd0, pc}, 32'h0);
    tick();
    reset = 1'b0;
    reg_valid = 1'b1;
    tick();
    check("ar_idle_hold", {16'd0, pc}, 32'h0);

`ifdef BRANCH_STATS_EN
    run_branch(16'hF100, 16'h0010, 1'b1, 16'h0010);
    run_branch(16'hF200, 16'h0020, 1'b0, 16'h0011);
    run_branch(16'hF300, 16'h0030, 1'b1, 16'h0030);
    check("st_taken_cnt", {16'd0, taken_count}, 32'h2);
    check("st_ntaken_cnt", {16'd0, not_taken_count}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
